// File: rtl/mips_run_pkg.sv
// rtl/mips_run_pkg.sv - shared types and constants for the mips run controller
//
// Contents:
//   run_state_t        controller state encoding
//   HALT_INSTR_DEFAULT default halt word (beq $0,$0,-1)
//   SIG_W              width of the execution-path signature register
package mips_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_RUN      = 3'd2,
    ST_HALTED   = 3'd3,
    ST_TIMEOUT  = 3'd4
  } run_state_t;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h1000FFFF;

  localparam int SIG_W = 32;

endpackage

// File: rtl/mips_stall_det.sv
// rtl/mips_stall_det.sv - pc-stall detector for the mips run controller
//
// Tracks how many consecutive active cycles the pc has repeated and flags
// the cycle in which the repeat count reaches STALL_LIMIT.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   clear  in   forget previous pc and repeat count (held before a run)
//   enable in   high during RUN cycles; updates prev pc and count
//   pc     in   current core pc
//   hit    out  combinational: this cycle makes the repeat count STALL_LIMIT
module mips_stall_det #(
  parameter int PC_W        = 32,
  parameter int STALL_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [PC_W-1:0] pc,
  output logic            hit
);

  localparam int SC_W = $clog2(STALL_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT = SC_W'(STALL_LIMIT);

  logic [PC_W-1:0] prev_pc;
  logic            pc_valid;
  logic [SC_W-1:0] stall_cnt;
  logic [SC_W-1:0] stall_nxt;

  // pc_valid keeps the first RUN cycle from comparing against a stale pc.
  always_comb begin
    stall_nxt = '0;
    if (pc_valid && (pc == prev_pc)) begin
      stall_nxt = (stall_cnt == LIMIT) ? LIMIT : stall_cnt + SC_W'(1);
    end
  end

  assign hit = enable && (stall_nxt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc   <= '0;
      pc_valid  <= 1'b0;
      stall_cnt <= '0;
    end else if (clear) begin
      pc_valid  <= 1'b0;
      stall_cnt <= '0;
    end else if (enable) begin
      prev_pc   <= pc;
      pc_valid  <= 1'b1;
      stall_cnt <= stall_nxt;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - bounded run sequencer for mips_processor
//
// Holds the core in reset for RST_CYCLES clocks after start, lets it run,
// and ends the run on a halt instruction, a pc stall of STALL_LIMIT
// repeats, or after MAX_CYCLES RUN cycles. Halt beats budget exhaustion
// when both happen in the same cycle.
//
// Optional feature macro: MIPS_RUN_SIG_EN adds sig_o, a rotate-xor
// signature of the pc stream over the run.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   one-cycle pulse; starts a run from IDLE/HALTED/TIMEOUT
//   pc_i         in   core pc
//   instr_i      in   core instruction
//   core_rst_o   out  active-high reset to the core
//   run_o        out  high in RUN
//   done_o       out  high in HALTED or TIMEOUT
//   halted_o     out  high in HALTED
//   timeout_o    out  high in TIMEOUT
//   cycle_cnt_o  out  RUN cycles completed in the current/last run
//   last_pc_o    out  pc sampled in the terminating RUN cycle
//   sig_o        out  pc signature (MIPS_RUN_SIG_EN only)
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int                 PC_W        = 32,
  parameter int                 INSTR_W     = 32,
  parameter int                 RST_CYCLES  = 2,
  parameter int                 MAX_CYCLES  = 40,
  parameter int                 STALL_LIMIT = 4,
  parameter logic [INSTR_W-1:0] HALT_INSTR  = INSTR_W'(HALT_INSTR_DEFAULT),
  parameter int                 CNT_W       = $clog2(MAX_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               core_rst_o,
  output logic               run_o,
  output logic               done_o,
  output logic               halted_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   cycle_cnt_o,
  output logic [PC_W-1:0]    last_pc_o
`ifdef MIPS_RUN_SIG_EN
  ,
  output logic [SIG_W-1:0]   sig_o
`endif
);

  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_CYCLES);

  run_state_t       state;
  logic [RST_W-1:0] rst_cnt;
  logic             in_run;
  logic             in_hold;
  logic             enter_run;
  logic             stall_hit;
  logic             halt_hit;

  assign in_run    = (state == ST_RUN);
  assign in_hold   = (state == ST_RST_HOLD);
  assign enter_run = in_hold && (rst_cnt == RST_LAST);

  mips_stall_det #(
    .PC_W        (PC_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_det (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (in_hold),
    .enable (in_run),
    .pc     (pc_i),
    .hit    (stall_hit)
  );

  assign halt_hit = in_run && ((instr_i == HALT_INSTR) || stall_hit);

  // Outputs are registered alongside the state so they change on the same
  // edge as the state they decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      rst_cnt     <= '0;
      core_rst_o  <= 1'b1;
      run_o       <= 1'b0;
      done_o      <= 1'b0;
      halted_o    <= 1'b0;
      timeout_o   <= 1'b0;
      cycle_cnt_o <= '0;
      last_pc_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RST_HOLD;
            rst_cnt <= '0;
          end
        end

        ST_RST_HOLD: begin
          if (enter_run) begin
            state       <= ST_RUN;
            cycle_cnt_o <= '0;
            core_rst_o  <= 1'b0;
            run_o       <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end

        ST_RUN: begin
          cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
          if (halt_hit) begin
            state      <= ST_HALTED;
            last_pc_o  <= pc_i;
            core_rst_o <= 1'b1;
            run_o      <= 1'b0;
            done_o     <= 1'b1;
            halted_o   <= 1'b1;
          end else if (cycle_cnt_o == CNT_LAST) begin
            state       <= ST_TIMEOUT;
            cycle_cnt_o <= CNT_MAX;
            last_pc_o   <= pc_i;
            core_rst_o  <= 1'b1;
            run_o       <= 1'b0;
            done_o      <= 1'b1;
            timeout_o   <= 1'b1;
          end
        end

        ST_HALTED, ST_TIMEOUT: begin
          // Counters and last pc hold here; they clear on entry to RUN.
          if (start) begin
            state     <= ST_RST_HOLD;
            rst_cnt   <= '0;
            done_o    <= 1'b0;
            halted_o  <= 1'b0;
            timeout_o <= 1'b0;
          end
        end

        default: begin
          state      <= ST_IDLE;
          core_rst_o <= 1'b1;
          run_o      <= 1'b0;
          done_o     <= 1'b0;
          halted_o   <= 1'b0;
          timeout_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MIPS_RUN_SIG_EN
  logic [SIG_W-1:0] pc_ext;

  if (PC_W >= SIG_W) begin : g_pc_trunc
    assign pc_ext = pc_i[SIG_W-1:0];
  end else begin : g_pc_zext
    assign pc_ext = {{(SIG_W - PC_W){1'b0}}, pc_i};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig_o <= '0;
    end else if (enter_run) begin
      sig_o <= '0;
    end else if (in_run) begin
      sig_o <= {sig_o[SIG_W-2:0], sig_o[SIG_W-1]} ^ pc_ext;
    end
  end
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb/tb_mips_run_ctrl.sv - self-checking bench for mips_run_ctrl
module tb_mips_run_ctrl;

  localparam int MAXC = 40;
  localparam int RSTC = 2;
  localparam int STL  = 4;
  localparam logic [31:0] HALT = 32'h1000FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pc_i = '0;
  logic [31:0] instr_i = '0;
  logic        core_rst_o;
  logic        run_o;
  logic        done_o;
  logic        halted_o;
  logic        timeout_o;
  logic [5:0]  cycle_cnt_o;
  logic [31:0] last_pc_o;
`ifdef MIPS_RUN_SIG_EN
  logic [31:0] sig_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] pc_seq    [0:MAXC+3];
  logic [31:0] instr_seq [0:MAXC+3];

  mips_run_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc_i        (pc_i),
    .instr_i     (instr_i),
    .core_rst_o  (core_rst_o),
    .run_o       (run_o),
    .done_o      (done_o),
    .halted_o    (halted_o),
    .timeout_o   (timeout_o),
    .cycle_cnt_o (cycle_cnt_o),
`ifdef MIPS_RUN_SIG_EN
    .sig_o       (sig_o),
`endif
    .last_pc_o   (last_pc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: halt word at cycle 4; 1: pc sticks at 8; 2: pc+4 forever;
  // 3: pc+4 with halt word at cycle 40; 4: random
  task automatic gen(input int mode);
    int p_stall;
    logic [31:0] v;
    p_stall = $urandom_range(0, 4);
    pc_seq[0] = '0;
    instr_seq[0] = '0;
    for (int k = 1; k <= MAXC + 3; k++) begin
      pc_seq[k]    = 32'(4 * (k - 1));
      instr_seq[k] = 32'h0;
      case (mode)
        0: if (k == 4) instr_seq[k] = HALT;
        1: if (k > 3) pc_seq[k] = 32'd8;
        3: if (k == MAXC) instr_seq[k] = HALT;
        4: begin
          v = $urandom;
          if (v == HALT) v = v ^ 32'h1;
          instr_seq[k] = ($urandom_range(0, 60) == 0) ? HALT : v;
          if (k == 1) pc_seq[k] = $urandom & 32'hFFFF_FFFC;
          else if ($urandom_range(0, 9) < p_stall) pc_seq[k] = pc_seq[k-1];
          else if ($urandom_range(0, 9) < 8) pc_seq[k] = pc_seq[k-1] + 32'd4;
          else pc_seq[k] = $urandom & 32'hFFFF_FFFC;
        end
        default: ;
      endcase
    end
  endtask

  // Reference: the run ends at the first cycle carrying the halt word or
  // whose pc equals each of the STL preceding RUN-cycle pcs; else at MAXC.
  task automatic model(output int n, output bit halted);
    bit stall;
    n = MAXC;
    halted = 1'b0;
    for (int k = 1; k <= MAXC; k++) begin
      stall = (k > STL);
      if (stall)
        for (int j = 1; j <= STL; j++)
          if (pc_seq[k-j] != pc_seq[k]) stall = 1'b0;
      if (instr_seq[k] == HALT || stall) begin
        n = k;
        halted = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_run(input int exp_n, input bit exp_halt, input bit poke_start);
    int k;
    bit ended;
    logic [31:0] s;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("hold_flags_drop", {done_o, halted_o, timeout_o}, 3'b000);
    for (int i = 0; i < RSTC; i++) begin
      check("hold_core_rst", {core_rst_o, run_o}, 2'b10);
      @(posedge clk); #1;
    end
    check("run_entry", {core_rst_o, run_o, done_o}, 3'b010);
    check("run_cnt0", cycle_cnt_o, 0);
    ended = 1'b0;
    k = 0;
    while (!ended && k < MAXC + 3) begin
      k++;
      pc_i    = pc_seq[k];
      instr_i = instr_seq[k];
      start   = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1 start = 1'b0;
      if (!run_o) ended = 1'b1;
    end
    check("run_len", k, exp_n);
    check("halted", halted_o, exp_halt);
    check("timeout", timeout_o, !exp_halt);
    check("done_core_rst", {done_o, core_rst_o, run_o}, 3'b110);
    check("cycle_cnt", cycle_cnt_o, exp_n);
    check("last_pc", last_pc_o, pc_seq[exp_n]);
    s = '0;
    for (int j = 1; j <= exp_n; j++) s = {s[30:0], s[31]} ^ pc_seq[j];
`ifdef MIPS_RUN_SIG_EN
    check("sig", sig_o, s);
`endif
    pc_i = $urandom;
    instr_i = HALT;
    repeat (3) @(posedge clk);
    #1;
    check("hold_cnt", cycle_cnt_o, exp_n);
    check("hold_pc", last_pc_o, pc_seq[exp_n]);
    check("hold_state", {done_o, halted_o, timeout_o}, {1'b1, exp_halt, !exp_halt});
  endtask

  task automatic reset_mid_run();
    gen(2);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (RSTC) @(posedge clk);
    #1;
    for (int k = 1; k <= 10; k++) begin
      pc_i = pc_seq[k];
      instr_i = '0;
      @(posedge clk); #1;
    end
    check("pre_reset_run", run_o, 1'b1);
    reset = 1'b0;
    #1;
    check("async_rst_flags", {core_rst_o, run_o, done_o, halted_o, timeout_o}, 5'b10000);
    check("async_rst_cnt", cycle_cnt_o, 0);
    check("async_rst_pc", last_pc_o, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", {core_rst_o, run_o, done_o}, 3'b100);
  endtask

  initial begin
    int n;
    bit h;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_flags", {core_rst_o, run_o, done_o, halted_o, timeout_o}, 5'b10000);
    check("idle_cnt", cycle_cnt_o, 0);
    check("idle_pc", last_pc_o, 0);

    gen(0); do_run(4, 1'b1, 1'b0);
    gen(1); do_run(7, 1'b1, 1'b0);
    gen(2); do_run(40, 1'b0, 1'b0);
    check("timeout_pc_156", last_pc_o, 32'd156);
    gen(3); do_run(40, 1'b1, 1'b0);

    reset_mid_run();

    for (int r = 0; r < 14; r++) begin
      gen(4);
      model(n, h);
      do_run(n, h, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Synthesizable run controller that sequences one bounded execution of mips_processor. It holds the core in reset for a programmable number of cycles, then lets it run. It monitors the core's pc and instruction for a halt condition and enforces a cycle budget. It reports done, halted or timeout, plus cycle count and final PC. This replaces fixed-count open-loop clocking with a parametrised, self-terminating run used in both simulation and on-board bring-up.

Parameters:
PC_W, 32, width of pc_i and last_pc_o
INSTR_W, 32, width of instr_i
RST_CYCLES, 2, cycles core_rst_o is held high after start (>=1)
MAX_CYCLES, 40, RUN-cycle budget before timeout (>=2)
STALL_LIMIT, 4, consecutive RUN cycles with unchanged pc that count as halt (>=1)
HALT_INSTR, 32'h1000FFFF, instruction word treated as halt (beq $0,$0,-1)
CNT_W, $clog2(MAX_CYCLES+1), width of cycle_cnt_o

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a run from IDLE, HALTED or TIMEOUT
pc_i  in  PC_W  current PC from core (o_pc)
instr_i  in  INSTR_W  current instruction from core
core_rst_o  out  1  active-high reset to mips_processor
run_o  out  1  high while in RUN
done_o  out  1  high in HALTED or TIMEOUT
halted_o  out  1  high in HALTED
timeout_o  out  1  high in TIMEOUT
cycle_cnt_o  out  CNT_W  RUN cycles completed in current/last run
last_pc_o  out  PC_W  pc_i sampled in terminating RUN cycle

Behaviour:
- Async reset (reset=0): state=IDLE; core_rst_o=1; run_o, done_o, halted_o, timeout_o=0; cycle_cnt_o=0; last_pc_o=0; internal rst_cnt, stall_cnt, prev_pc=0, pc_valid=0.
- States: IDLE, RST_HOLD, RUN, HALTED, TIMEOUT. All outputs are registered and decoded from state.
- IDLE: core_rst_o=1. start=1 -> RST_HOLD next edge, rst_cnt=0.
- RST_HOLD: core_rst_o=1 for exactly RST_CYCLES clocks. Then -> RUN; cycle_cnt=0; stall_cnt=0; pc_valid=0. start is ignored.
- RUN: core_rst_o=0, run_o=1. Each edge: cycle_cnt+1, prev_pc<=pc_i, pc_valid<=1.
- Stall: if pc_valid and pc_i==prev_pc then stall_cnt+1, else stall_cnt=0. stall_cnt saturates at STALL_LIMIT.
- Halt condition in a RUN cycle: instr_i==HALT_INSTR, or the stall_cnt next value ==STALL_LIMIT. The first RUN cycle never counts as a stall.
- Halt -> HALTED; last_pc_o<=pc_i; cycle_cnt includes this cycle.
- Budget: if no halt and cycle_cnt==MAX_CYCLES-1 -> TIMEOUT; cycle_cnt becomes MAX_CYCLES; last_pc_o<=pc_i.
- Halt and budget exhaustion in the same cycle: HALTED wins, timeout_o=0.
- start during RUN is ignored.
- HALTED/TIMEOUT: core_rst_o=1 (core frozen), done_o=1; cycle_cnt_o and last_pc_o hold. start -> RST_HOLD; the done flags drop on that edge; counters clear on entry to RUN.
- reset asserted mid-run: immediate return to reset values; core_rst_o=1 asynchronously.
- Counter arithmetic is unsigned. cycle_cnt never exceeds MAX_CYCLES, so there is no wrap.

Optional Feature:
MIPS_RUN_SIG_EN: adds output sig_o [31:0].
- Cleared on entry to RUN.
- Each RUN cycle: sig <= {sig[30:0],sig[31]} ^ pc_i[31:0], zero-extended if PC_W<32.
- Holds in HALTED/TIMEOUT; reset value 0.
- Used as a compact execution-path signature for regression compare.
- Without the macro: no port, no logic.

Decomposition:
- Package mips_run_pkg holds the state enum typedef (run_state_t), the default HALT_INSTR constant, and the signature rotate width constant (SIG_W=32).
- One sub-module is natural: mips_stall_det (prev_pc register, compare, saturating stall counter, halt-detect output), instantiated once.
- Everything else stays in mips_run_ctrl.

Test Plan:
1. Reset/idle: reset=0 then 1, no start -> core_rst_o=1, all flags 0, cycle_cnt_o=0 indefinitely.
2. Reset hold: start pulse, RST_CYCLES=2 -> core_rst_o high exactly 2 cycles after start edge, then run_o=1.
3. Halt instruction: pc_i=0,4,8,12, instr_i=HALT_INSTR on 4th RUN cycle -> halted_o=1 next edge, cycle_cnt_o=4, last_pc_o=12, timeout_o=0.
4. PC stall: pc_i=0,4,8 then 8 held, STALL_LIMIT=4 -> halt after 4 repeats, cycle_cnt_o=7, last_pc_o=8.
5. Timeout: pc_i increments by 4 each cycle, MAX_CYCLES=40 -> timeout_o=1, cycle_cnt_o=40, last_pc_o=156.
6. Edge cases:
   - HALT_INSTR on RUN cycle 40 -> halted_o=1, timeout_o=0.
   - reset low mid-RUN -> all outputs at reset values within the same cycle.
   - start in TIMEOUT -> new run with cycle_cnt_o restarting from 0.
